// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx
//
// Receive side of the MSB-first serial word link. Collects WIDTH serial bits
// per frame, assembles them into a parallel word and presents that word on a
// valid/ready output port. Flags frame resynchronisation and dropped words.
//
// Ports:
//   clk         single clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   din         serial data bit, MSB first
//   din_valid   din (and start) are sampled only when this is 1
//   start       frame marker, the din of this sample is the frame MSB
//   data_out    assembled word, stable while data_valid=1 and data_ready=0
//   data_valid  data_out holds a word the consumer has not yet taken
//   data_ready  consumer takes the word when data_valid & data_ready
//   busy        a frame is in progress (registered)
//   sync_err    sticky: start arrived in the middle of a frame
//   overrun     sticky: a completed word was dropped because the output was full
//   clr_err     synchronous clear of sync_err and overrun (a new event wins)

module serial_to_parallel_rx #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             start,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             sync_err,
    output logic             overrun,
    input  logic             clr_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Counter value of the sample that carries the LSB of the frame.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               data_valid_q, data_valid_d;
    logic               busy_q, busy_d;
    logic               sync_err_q, sync_err_d;
    logic               overrun_q, overrun_d;

    // Combinational helpers
    logic [WIDTH-1:0]   shifted_word;   // shift register with this cycle's din appended
    logic [WIDTH-1:0]   first_word;     // fresh frame holding only the MSB
    logic               word_done;      // this sample completes a frame
    logic               sync_event;     // start seen mid-frame
    logic               overrun_event;  // completed word cannot be stored

    assign shifted_word = {shift_q[WIDTH-2:0], din};
    assign first_word   = {{(WIDTH-1){1'b0}}, din};

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        word_done     = 1'b0;
        sync_event    = 1'b0;
        overrun_event = 1'b0;

        // A word taken by the consumer frees the output register; a completion
        // in this same cycle may refill it below.
        if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end

        if (din_valid) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_d = first_word;
                        cnt_d   = CNT_ONE;
                        state_d = RECV;
                    end
                end
                RECV: begin
                    if (start) begin
                        // Resync: throw away the partial word and restart
                        // with this bit as the new MSB.
                        sync_event = 1'b1;
                        shift_d    = first_word;
                        cnt_d      = CNT_ONE;
                    end else if (cnt_q == LAST_CNT) begin
                        word_done = 1'b1;
                        shift_d   = shifted_word;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        shift_d = shifted_word;
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (word_done) begin
            if (!data_valid_q || data_ready) begin
                data_out_d   = shifted_word;
                data_valid_d = 1'b1;
            end else begin
                // Output still full and not being taken: drop the new word,
                // keep the held one intact.
                overrun_event = 1'b1;
            end
        end

        busy_d     = (state_d == RECV);
        sync_err_d = (sync_err_q & ~clr_err) | sync_event;
        overrun_d  = (overrun_q  & ~clr_err) | overrun_event;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            sync_err_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            sync_err_q   <= sync_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign sync_err   = sync_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
module tb_serial_to_parallel_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    logic        din_valid;
    logic        start;
    logic [31:0] data_out;
    logic        data_valid;
    logic        data_ready;
    logic        busy;
    logic        sync_err;
    logic        overrun;
    logic        clr_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    serial_to_parallel_rx #(.WIDTH(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .start      (start),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .sync_err   (sync_err),
        .overrun    (overrun),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    // Watchdog: the whole run is a fixed number of cycles, far below this.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic st);
        din       = b;
        start     = st;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        start     = 1'b0;
        din       = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) begin
            send_bit(w[i], i == 31);
        end
    endtask

    function automatic logic [31:0] pop_exp();
        if (exp_q.size() == 0) return 32'hxxxx_xxxx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        logic [31:0] e;
        rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; start = 1'b0;
        data_ready = 1'b0; clr_err = 1'b0;
        tick();
        tick();
        total++;
        if (data_out !== 32'h0 || data_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got data_out=%h valid=%b busy=%b, required 0/0/0",
                     data_out, data_valid, busy);
        end
        total++;
        if (sync_err !== 1'b0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got sync_err=%b overrun=%b, required 0/0", sync_err, overrun);
        end
        rst_n = 1'b1;
        tick();
        e = 32'h0;
        $display("reset: data_out=%h (expected %h)", data_out, e);
    endtask

    task automatic test_nominal();
        logic [31:0] e;
        int busy_cnt;
        data_ready = 1'b1;
        // Samples without start in IDLE must be ignored.
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        total++;
        if (busy !== 1'b0 || data_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_ignore: got busy=%b valid=%b, required 0/0", busy, data_valid);
        end
        exp_q.push_back(32'hA5C3_0F81);
        busy_cnt = 0;
        for (int i = 31; i >= 0; i--) begin
            send_bit(e_bit(32'hA5C3_0F81, i), i == 31);
            if (busy === 1'b1) busy_cnt++;
        end
        e = pop_exp();
        total++;
        if (data_valid !== 1'b1 || data_out !== e) begin
            bad++;
            $display("FAIL nominal_word: got valid=%b data_out=%h, required 1 %h", data_valid, data_out, e);
        end
        $display("nominal: word %h (expected %h)", data_out, e);
        total++;
        if (busy_cnt != 31) begin
            bad++;
            $display("FAIL nominal_busy_cycles: got %0d, required 31", busy_cnt);
        end
        tick();
        total++;
        if (data_valid !== 1'b0) begin
            bad++;
            $display("FAIL nominal_valid_pulse: got valid=%b, required 0", data_valid);
        end
        total++;
        if (sync_err !== 1'b0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL nominal_flags: got sync_err=%b overrun=%b, required 0/0", sync_err, overrun);
        end
    endtask

    function automatic logic e_bit(input logic [31:0] w, input int i);
        return w[i];
    endfunction

    task automatic test_stall();
        logic [31:0] w;
        logic [31:0] e;
        w = 32'hA5C3_0F81;
        data_ready = 1'b1;
        exp_q.push_back(w);
        for (int i = 31; i >= 0; i--) begin
            send_bit(w[i], i == 31);
            if (i == 1) begin
                total++;
                if (data_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_early: got valid=%b after 31 samples, required 0", data_valid);
                end
            end
            if (i != 0) tick();
        end
        e = pop_exp();
        total++;
        if (data_valid !== 1'b1 || data_out !== e || sync_err !== 1'b0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL stall_word: got valid=%b data_out=%h se=%b ov=%b, required 1 %h 0 0",
                     data_valid, data_out, sync_err, overrun, e);
        end
        $display("stall: word %h (expected %h)", data_out, e);
        tick();
    endtask

    task automatic test_resync();
        logic [31:0] e;
        data_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_bit(1'b1, i == 0);
        total++;
        if (busy !== 1'b1 || sync_err !== 1'b0) begin
            bad++;
            $display("FAIL resync_partial: got busy=%b sync_err=%b, required 1/0", busy, sync_err);
        end
        exp_q.push_back(32'h1234_5678);
        send_word(32'h1234_5678);
        e = pop_exp();
        total++;
        if (data_valid !== 1'b1 || data_out !== e) begin
            bad++;
            $display("FAIL resync_word: got valid=%b data_out=%h, required 1 %h", data_valid, data_out, e);
        end
        $display("resync: word %h (expected %h)", data_out, e);
        tick();
        total++;
        if (sync_err !== 1'b1) begin
            bad++;
            $display("FAIL resync_sticky: got sync_err=%b, required 1", sync_err);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        total++;
        if (sync_err !== 1'b0) begin
            bad++;
            $display("FAIL resync_clear: got sync_err=%b, required 0", sync_err);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] e;
        data_ready = 1'b0;
        exp_q.push_back(32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF);
        e = pop_exp();
        total++;
        if (data_valid !== 1'b1 || data_out !== e || overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_first: got valid=%b data_out=%h ov=%b, required 1 %h 0",
                     data_valid, data_out, overrun, e);
        end
        $display("overrun: held word %h (expected %h)", data_out, e);
        // Second word is dropped: nothing pushed to the scoreboard.
        send_word(32'h0BAD_F00D);
        total++;
        if (data_valid !== 1'b1 || data_out !== e || overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_drop: got valid=%b data_out=%h ov=%b, required 1 %h 1",
                     data_valid, data_out, overrun, e);
        end
        data_ready = 1'b1;
        tick();
        total++;
        if (data_valid !== 1'b0) begin
            bad++;
            $display("FAIL overrun_accept: got valid=%b, required 0", data_valid);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clear: got overrun=%b, required 0", overrun);
        end
    endtask

    task automatic test_refill();
        logic [31:0] e;
        logic [31:0] w;
        data_ready = 1'b0;
        exp_q.push_back(32'h1111_1111);
        send_word(32'h1111_1111);
        e = pop_exp();
        total++;
        if (data_valid !== 1'b1 || data_out !== e) begin
            bad++;
            $display("FAIL refill_hold: got valid=%b data_out=%h, required 1 %h", data_valid, data_out, e);
        end
        $display("refill: held word %h (expected %h)", data_out, e);
        w = 32'h2222_2222;
        exp_q.push_back(w);
        for (int i = 31; i >= 0; i--) begin
            if (i == 0) data_ready = 1'b1;
            send_bit(w[i], i == 31);
        end
        e = pop_exp();
        total++;
        if (data_valid !== 1'b1 || data_out !== e || overrun !== 1'b0) begin
            bad++;
            $display("FAIL refill_word: got valid=%b data_out=%h ov=%b, required 1 %h 0",
                     data_valid, data_out, overrun, e);
        end
        $display("refill: word %h (expected %h)", data_out, e);
        tick();
        total++;
        if (data_valid !== 1'b0) begin
            bad++;
            $display("FAIL refill_drain: got valid=%b, required 0", data_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        data_ready = 1'b1;
        exp_q.push_back(32'h0F0F_3C3C);
        exp_q.push_back(32'hF0F0_C3C3);
        send_word(32'h0F0F_3C3C);
        e = pop_exp();
        total++;
        if (data_valid !== 1'b1 || data_out !== e) begin
            bad++;
            $display("FAIL b2b_first: got valid=%b data_out=%h, required 1 %h", data_valid, data_out, e);
        end
        $display("back_to_back: word %h (expected %h)", data_out, e);
        send_word(32'hF0F0_C3C3);
        e = pop_exp();
        total++;
        if (data_valid !== 1'b1 || data_out !== e || sync_err !== 1'b0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: got valid=%b data_out=%h se=%b ov=%b, required 1 %h 0 0",
                     data_valid, data_out, sync_err, overrun, e);
        end
        $display("back_to_back: word %h (expected %h)", data_out, e);
        tick();
    endtask

    task automatic test_async_reset();
        logic [31:0] e;
        logic [31:0] w;
        data_ready = 1'b0;
        exp_q.push_back(32'h55AA_33CC);
        send_word(32'h55AA_33CC);
        e = pop_exp();
        total++;
        if (data_valid !== 1'b1 || data_out !== e) begin
            bad++;
            $display("FAIL areset_hold: got valid=%b data_out=%h, required 1 %h", data_valid, data_out, e);
        end
        $display("async_reset: held word %h (expected %h)", data_out, e);
        send_word(32'h7777_7777);   // dropped, sets overrun
        w = 32'h8000_0001;
        for (int i = 31; i >= 16; i--) send_bit(w[i], i == 31);
        total++;
        if (busy !== 1'b1 || overrun !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre: got busy=%b overrun=%b, required 1/1", busy, overrun);
        end
        rst_n = 1'b0;   // between clock edges
        #1;
        total++;
        if (data_out !== 32'h0 || data_valid !== 1'b0 || busy !== 1'b0 ||
            sync_err !== 1'b0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL areset_immediate: got data_out=%h valid=%b busy=%b se=%b ov=%b, required all 0",
                     data_out, data_valid, busy, sync_err, overrun);
        end
        tick();
        rst_n = 1'b1;
        tick();
        data_ready = 1'b1;
        exp_q.push_back(w);
        send_word(w);
        e = pop_exp();
        total++;
        if (data_valid !== 1'b1 || data_out !== e || overrun !== 1'b0) begin
            bad++;
            $display("FAIL areset_after: got valid=%b data_out=%h ov=%b, required 1 %h 0",
                     data_valid, data_out, overrun, e);
        end
        $display("async_reset: word %h (expected %h)", data_out, e);
        tick();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_resync();
        test_overrun();
        test_refill();
        test_back_to_back();
        test_async_reset();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got %0d pending words, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
